effect_crossfade_router: RTL

- Parametrised successor to the fixed switch-driven effect mux between the ADC/effect chain and AudioDAC.
- Selects one of NUM_FX effect streams or the dry ADC stream for the DAC data word.
- Replaces the hard cut with a linear crossfade over FADE_LEN frames, so changing effect does not click.
- Width, channel count, effect count and fade length are parameters; switching is frame-synchronous.

---
 rtl/audio_pkg.sv | 27 ++
 rtl/xfade_lane.sv | 64 ++++++
 rtl/effect_crossfade_router.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: FSM state encodings, frame width helper and
// the one-hot switch decode used by switch-selected blocks.
package audio_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FADE = 1'b1;

  function automatic int FRAME_W(input int channels, input int sample_w);
    return channels * sample_w;
  endfunction

  // Exactly one bit i set (within the low n bits) gives i+1; anything else gives 0.
  function automatic int onehot_to_idx(input logic [31:0] v, input int n);
    int cnt;
    int idx;
    cnt = 0;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < n && v[i]) begin
        cnt = cnt + 1;
        idx = i + 1;
      end
    end
    return (cnt == 1) ? idx : 0;
  endfunction

endpackage

// File: rtl/xfade_lane.sv
// One channel of the crossfade: (a*(2^L-k) + b*k) >>> L, floor rounding.
// MAKEUP_GAIN_EN adds a per-input left shift with signed saturation ahead of the mix.
module xfade_lane #(
  parameter int SAMPLE_W  = 16,
  parameter int FADE_LOG2 = 6
) (
  input  logic signed [SAMPLE_W-1:0] i_a,
  input  logic signed [SAMPLE_W-1:0] i_b,
  input  logic        [FADE_LOG2:0]  i_k,
`ifdef MAKEUP_GAIN_EN
  input  logic        [2:0]          i_shl_a,
  input  logic        [2:0]          i_shl_b,
`endif
  output logic signed [SAMPLE_W-1:0] o_y
);

  localparam int MW = SAMPLE_W + FADE_LOG2 + 2;
  localparam logic [FADE_LOG2:0] FADE_LEN = {1'b1, {FADE_LOG2{1'b0}}};

  logic signed [SAMPLE_W-1:0] w_a;
  logic signed [SAMPLE_W-1:0] w_b;

`ifdef MAKEUP_GAIN_EN
  localparam int GW = SAMPLE_W + 8;
  localparam logic signed [GW-1:0] SAT_MAX = {{(GW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [GW-1:0] SAT_MIN = {{(GW-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  function automatic logic signed [SAMPLE_W-1:0] gain_sat(
    input logic signed [SAMPLE_W-1:0] s,
    input logic        [2:0]          shl
  );
    logic signed [GW-1:0] v;
    v = {{8{s[SAMPLE_W-1]}}, s} <<< shl;
    if (v > SAT_MAX)      return SAT_MAX[SAMPLE_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[SAMPLE_W-1:0];
    else                  return v[SAMPLE_W-1:0];
  endfunction

  assign w_a = gain_sat(i_a, i_shl_a);
  assign w_b = gain_sat(i_b, i_shl_b);
`else
  assign w_a = i_a;
  assign w_b = i_b;
`endif

  logic        [FADE_LOG2:0] w_ka;
  logic signed [MW-1:0]      w_ae;
  logic signed [MW-1:0]      w_be;
  logic signed [MW-1:0]      w_wa;
  logic signed [MW-1:0]      w_wb;
  logic signed [MW-1:0]      w_sum;
  logic signed [MW-1:0]      w_shr;

  assign w_ka  = FADE_LEN - i_k;
  assign w_ae  = {{(MW-SAMPLE_W){w_a[SAMPLE_W-1]}}, w_a};
  assign w_be  = {{(MW-SAMPLE_W){w_b[SAMPLE_W-1]}}, w_b};
  assign w_wa  = {{(MW-FADE_LOG2-1){1'b0}}, w_ka};
  assign w_wb  = {{(MW-FADE_LOG2-1){1'b0}}, i_k};
  // Convex combination: the shifted sum always fits back into SAMPLE_W.
  assign w_sum = w_ae * w_wa + w_be * w_wb;
  assign w_shr = w_sum >>> FADE_LOG2;
  assign o_y   = w_shr[SAMPLE_W-1:0];

endmodule

// File: rtl/effect_crossfade_router.sv
// Frame-synchronous dry/effect selector feeding AudioDAC with a linear crossfade
// on every source change. Optional per-source makeup gain: MAKEUP_GAIN_EN.
//
// state | meaning
// IDLE  | passing the committed source cur_src straight through
// FADE  | mixing cur_src toward tgt, weight k advancing one step per frame
module effect_crossfade_router
  import audio_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int CHANNELS  = 2,
  parameter int NUM_FX    = 4,
  parameter int FADE_LOG2 = 6
`ifdef MAKEUP_GAIN_EN
  ,
  parameter logic [3*(NUM_FX+1)-1:0] GAIN_SHL = '0
`endif
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            frame_valid,
  input  logic [CHANNELS*SAMPLE_W-1:0]                    dry_in,
  input  logic [NUM_FX*CHANNELS*SAMPLE_W-1:0]             fx_in,
  input  logic [NUM_FX-1:0]                               sel,
  output logic [CHANNELS*SAMPLE_W-1:0]                    audio_out,
  output logic                                            out_valid,
  output logic                                            busy,
  output logic [$clog2(NUM_FX+1)-1:0]                     cur_src
);

  localparam int FW    = FRAME_W(CHANNELS, SAMPLE_W);
  localparam int IDX_W = $clog2(NUM_FX + 1);
  localparam logic [FADE_LOG2:0] K_ONE  = {{FADE_LOG2{1'b0}}, 1'b1};
  localparam logic [FADE_LOG2:0] K_LAST = {1'b0, {FADE_LOG2{1'b1}}};

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_cur;
  logic [IDX_W-1:0] r_tgt;
  logic [IDX_W-1:0] r_pending;
  logic             r_pend_valid;
  logic [FADE_LOG2:0] r_k;
  logic [FW-1:0]    r_out;
  logic             r_out_valid;

  logic [0:0]       w_nxt_state;
  logic [IDX_W-1:0] w_nxt_cur;
  logic [IDX_W-1:0] w_nxt_tgt;
  logic [IDX_W-1:0] w_nxt_pending;
  logic             w_nxt_pend_valid;
  logic [FADE_LOG2:0] w_nxt_k;

  logic [IDX_W-1:0] w_dec;
  logic [IDX_W-1:0] w_a_idx;
  logic [IDX_W-1:0] w_b_idx;
  logic [FADE_LOG2:0] w_k;
  logic [FW-1:0]    w_src [NUM_FX+1];
  logic [FW-1:0]    w_src_a;
  logic [FW-1:0]    w_src_b;
  logic [FW-1:0]    w_mix;

  assign w_dec    = IDX_W'(onehot_to_idx(32'(sel), NUM_FX));
  assign w_src[0] = dry_in;

  for (genvar i = 0; i < NUM_FX; i++) begin : g_src
    assign w_src[i+1] = fx_in[i*FW +: FW];
  end

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_cur        = r_cur;
    w_nxt_tgt        = r_tgt;
    w_nxt_pending    = r_pending;
    w_nxt_pend_valid = r_pend_valid;
    w_nxt_k          = r_k;
    w_a_idx          = r_cur;
    w_b_idx          = r_cur;
    w_k              = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_dec != r_cur) begin
          w_b_idx     = w_dec;
          w_k         = K_ONE;
          w_nxt_tgt   = w_dec;
          w_nxt_k     = K_ONE;
          w_nxt_state = ST_FADE;
        end
      end
      ST_FADE: begin
        if (r_k == K_LAST) begin
          // Return frame: commit tgt, then chain straight into any pending change.
          w_nxt_cur        = r_tgt;
          w_nxt_pend_valid = 1'b0;
          w_a_idx          = r_tgt;
          w_b_idx          = r_tgt;
          if (r_pend_valid && (r_pending != r_tgt)) begin
            w_b_idx   = r_pending;
            w_k       = K_ONE;
            w_nxt_tgt = r_pending;
            w_nxt_k   = K_ONE;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end else begin
          w_b_idx          = r_tgt;
          w_k              = r_k + K_ONE;
          w_nxt_k          = r_k + K_ONE;
          w_nxt_pending    = w_dec;
          w_nxt_pend_valid = 1'b1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_src_a = '0;
    w_src_b = '0;
    for (int i = 0; i <= NUM_FX; i++) begin
      if (w_a_idx == IDX_W'(i)) w_src_a = w_src[i];
      if (w_b_idx == IDX_W'(i)) w_src_b = w_src[i];
    end
  end

`ifdef MAKEUP_GAIN_EN
  logic [2:0] w_shl_a;
  logic [2:0] w_shl_b;

  always_comb begin
    w_shl_a = '0;
    w_shl_b = '0;
    for (int i = 0; i <= NUM_FX; i++) begin
      if (w_a_idx == IDX_W'(i)) w_shl_a = GAIN_SHL[3*i +: 3];
      if (w_b_idx == IDX_W'(i)) w_shl_b = GAIN_SHL[3*i +: 3];
    end
  end
`endif

  // Channel 0 sits in the MS bits, matching the {left,right} packing.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    xfade_lane #(
      .SAMPLE_W (SAMPLE_W),
      .FADE_LOG2(FADE_LOG2)
    ) u_lane (
      .i_a    (w_src_a[FW-1-c*SAMPLE_W -: SAMPLE_W]),
      .i_b    (w_src_b[FW-1-c*SAMPLE_W -: SAMPLE_W]),
      .i_k    (w_k),
`ifdef MAKEUP_GAIN_EN
      .i_shl_a(w_shl_a),
      .i_shl_b(w_shl_b),
`endif
      .o_y    (w_mix[FW-1-c*SAMPLE_W -: SAMPLE_W])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cur        <= '0;
      r_tgt        <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_k          <= '0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_out_valid <= frame_valid;
      if (frame_valid) begin
        r_state      <= w_nxt_state;
        r_cur        <= w_nxt_cur;
        r_tgt        <= w_nxt_tgt;
        r_pending    <= w_nxt_pending;
        r_pend_valid <= w_nxt_pend_valid;
        r_k          <= w_nxt_k;
        r_out        <= w_mix;
      end
    end
  end

  assign audio_out = r_out;
  assign out_valid = r_out_valid;
  assign busy      = (r_state == ST_FADE);
  assign cur_src   = r_cur;

endmodule
